prbs_checker_mlane: RTL and testbench
=====================================

Name: prbs_checker_mlane

Overview:
- Parallel-word PRBS checker. Each clock it checks n_width deserialized bits, either ADC slicer bits or FFE estimated bits.
- Successor to the fixed-mode checker. Adds a parametrised word width and polynomial length, self-seeding, an input-valid qualifier, automatic lock-loss detection with re-seed, and saturating counters.
- Sits in the digital core after the PRBS source mux. Counters are read out over JTAG.

Parameters:
- n_width, 16, bits checked per clock (channel width)
- n_prbs, 32, maximum LFSR length / tap vector width
- n_cnt, 64, width of err_bits and total_bits
- n_relock, 16, width of relock_count
- n_thresh, 5, width of lock_thresh and lock_loss_cycles

Ports:
- clk, input, 1, checker clock (clk_adc domain)
- rstb, input, 1, asynchronous active-low reset
- rx_data, input, n_width, received word; bit 0 is the earliest bit
- rx_valid, input, 1, rx_data qualifier
- prbs_eqn, input, n_prbs, tap vector; bit k set means tap b[n-1-k]
- invert, input, 1, invert rx_data before checking
- checker_mode, input, 2, 0=RESET, 1=ALIGN, 2=RUN, 3=FREEZE
- lock_thresh, input, n_thresh, per-word error count that counts as bad
- lock_loss_cycles, input, n_thresh, consecutive bad words that trigger a re-seed (0 disables)
- err_bits, output, n_cnt, accumulated bit errors
- total_bits, output, n_cnt, accumulated checked bits
- relock_count, output, n_relock, number of automatic re-seeds
- locked, output, 1, LFSR is seeded and tracking
- err_signals, output, n_width, per-bit mismatch of the last checked word

Behaviour:
- Reset (rstb=0, asynchronous): every output is 0, history is cleared, FSM goes to IDLE.
- Prediction: b[n] = XOR over all k with prbs_eqn[k]=1 of b[n-1-k]. The word predictor advances the LFSR n_width steps per valid word using an unrolled combinational function.
- History register: holds the last n_prbs received (post-invert) bits. It shifts by n_width on each rx_valid; no shift otherwise.
- FSM states: IDLE, SEED, TRACK.
  - IDLE: entered whenever checker_mode=0. Counters, relock_count, err_signals and locked all clear synchronously.
  - IDLE -> SEED when checker_mode != 0.
  - SEED: counts valid words. After ceil(n_prbs/n_width) valid words, LFSR state := history and the FSM moves to TRACK with locked=1.
  - An all-zero history is a degenerate seed: stay in SEED and restart the word count.
  - TRACK: on each valid word the predicted word is compared with the received word. The LFSR then advances (free-running, not self-synchronising, so one flipped bit gives exactly one error).
- Pipeline: stage 1 registers rx_data/rx_valid after inversion; stage 2 compares and registers err_signals; stage 3 updates the counters.
  - err_signals updates 2 clocks after the word is presented; the counters update 3 clocks after.
  - err_signals holds its value on invalid cycles.
- Counting: only in TRACK with checker_mode=2 and the word valid.
  - total_bits += n_width; err_bits += popcount(err_signals).
  - Both counters saturate at all-ones and never wrap.
- ALIGN (mode 1): seeds and tracks; counters hold.
- FREEZE (mode 3): counters and relock_count hold. Tracking and lock-loss detection continue, but a relock in FREEZE does not increment relock_count.
- Lock loss (TRACK, lock_loss_cycles != 0):
  - A valid word with popcount >= lock_thresh increments the bad counter. A good valid word clears it. Invalid words leave it unchanged.
  - When the bad counter reaches lock_loss_cycles: locked=0 next clock, FSM -> SEED, history is kept, and relock_count increments (saturating, modes 1/2 only).
  - The word that triggers the relock is still counted.
- Simultaneous events: checker_mode=0 has priority over lock loss and counting.
- Changing prbs_eqn while in TRACK takes effect on the next prediction; no automatic re-seed.
- Reset mid-operation: an asynchronous clear, even mid-pipeline. No partial counter update completes.

Test Plan:
- Clean PRBS21 (prbs_eqn bits 1 and 20), n_width=16, mode 1 for 10 cycles then mode 2 for 1000 valid words -> locked=1 after 2 valid words in SEED, err_bits=0, total_bits=16000, relock_count=0.
- Same as above, with a single bit flipped at rx_data[5] of word 500 -> err_bits=1, err_signals=16'h0020 for that word, locked stays 1.
- Bit-inverted stream: invert=1 -> err_bits=0. Then invert=0 with lock_thresh=4, lock_loss_cycles=3 -> locked falls after 3 bad words, relock_count=1, then the checker re-locks on the inverted data.
- rx_valid toggling 1,0,1,0 for 2000 cycles in mode 2 -> total_bits=16000, err_bits=0, history and LFSR do not advance on invalid cycles.
- Mode 3 with 5 injected errors -> err_bits and total_bits unchanged. Mode 0 for 1 cycle -> all outputs 0, FSM re-seeds when mode returns to 1.
- n_cnt=8 build, clean data in mode 2 for 20 words -> total_bits saturates at 255 and holds. All-zero input -> stays in SEED, locked=0.

Source files
------------

// File: rtl/prbs_checker_mlane.sv
// prbs_checker_mlane: parallel-word PRBS checker with self-seeding,
// input-valid qualification, automatic lock-loss re-seed and saturating
// bit/error counters. Each valid word carries n_width bits, bit 0 earliest.
// Pipeline: stage 1 captures (optionally inverted) data, stage 2 compares
// against the LFSR prediction, stage 3 accumulates the counters.

module prbs_checker_mlane #(
    parameter int n_width  = 16,
    parameter int n_prbs   = 32,
    parameter int n_cnt    = 64,
    parameter int n_relock = 16,
    parameter int n_thresh = 5
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic [n_width-1:0]  rx_data,
    input  logic                rx_valid,
    input  logic [n_prbs-1:0]   prbs_eqn,
    input  logic                invert,
    input  logic [1:0]          checker_mode,
    input  logic [n_thresh-1:0] lock_thresh,
    input  logic [n_thresh-1:0] lock_loss_cycles,
    output logic [n_cnt-1:0]    err_bits,
    output logic [n_cnt-1:0]    total_bits,
    output logic [n_relock-1:0] relock_count,
    output logic                locked,
    output logic [n_width-1:0]  err_signals
);

    // Number of valid words needed to fill the history with fresh bits.
    localparam int seed_words = (n_prbs + n_width - 1) / n_width;
    localparam int seed_w     = $clog2(seed_words + 1);
    localparam int pop_w      = $clog2(n_width + 1);

    localparam logic [1:0] mode_reset  = 2'd0;
    localparam logic [1:0] mode_align  = 2'd1;
    localparam logic [1:0] mode_run    = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEED  = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [n_width-1:0]  data_s1;
    logic                valid_s1;
    logic [n_prbs-1:0]   history;
    logic [n_prbs-1:0]   hist_next;
    logic [n_prbs-1:0]   lfsr;
    logic [seed_w-1:0]   seed_cnt;
    logic [n_thresh-1:0] bad_cnt;
    logic [n_width-1:0]  pred_word;
    logic [n_width-1:0]  err_now;
    logic [pop_w-1:0]    err_pop;
    logic                count_en;
    logic                mode_active;
    logic                seed_done;
    logic                seed_zero;
    logic                track_word;
    logic                word_bad;
    logic                loss_hit;
    logic                load_seed;
    logic                count_now;
    logic                relock_inc;
    logic [n_cnt:0]      total_sum;
    logic [n_cnt:0]      err_sum;

    // Shift a word into a bit history, earliest bit first; the newest bit
    // ends up at index 0, so index k always holds b[n-1-k].
    function automatic logic [n_prbs-1:0] shift_in(input logic [n_prbs-1:0] hist,
                                                   input logic [n_width-1:0] word);
        logic [n_prbs-1:0] h;
        h = hist;
        for (int i = 0; i < n_width; i++) begin
            h = {h[n_prbs-2:0], word[i]};
        end
        return h;
    endfunction

    // Unrolled word predictor: n_width serial LFSR steps in one cycle.
    function automatic logic [n_width-1:0] predict(input logic [n_prbs-1:0] st,
                                                   input logic [n_prbs-1:0] eqn);
        logic [n_prbs-1:0]  s;
        logic [n_width-1:0] w;
        s = st;
        w = '0;
        for (int i = 0; i < n_width; i++) begin
            w[i] = ^(s & eqn);
            s    = {s[n_prbs-2:0], w[i]};
        end
        return w;
    endfunction

    function automatic logic [pop_w-1:0] popcount(input logic [n_width-1:0] w);
        logic [pop_w-1:0] c;
        c = '0;
        for (int i = 0; i < n_width; i++) begin
            c = c + pop_w'(w[i]);
        end
        return c;
    endfunction

    assign mode_active = (checker_mode != mode_reset);
    assign hist_next   = shift_in(history, data_s1);
    assign pred_word   = predict(lfsr, prbs_eqn);
    assign err_now     = pred_word ^ data_s1;
    assign err_pop     = popcount(err_now);
    assign seed_done   = valid_s1 && (seed_cnt == seed_w'(seed_words - 1));
    assign seed_zero   = (hist_next == '0);
    assign track_word  = (state == TRACK) && valid_s1 && mode_active;
    assign word_bad    = (int'(err_pop) >= int'(lock_thresh));
    assign loss_hit    = track_word && (lock_loss_cycles != '0) && word_bad &&
                         (({1'b0, bad_cnt} + (n_thresh + 1)'(1)) >= {1'b0, lock_loss_cycles});
    assign total_sum   = {1'b0, total_bits} + (n_cnt + 1)'(n_width);
    assign err_sum     = {1'b0, err_bits} + (n_cnt + 1)'(popcount(err_signals));

    // Stage 1: capture the received word after optional inversion.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            data_s1  <= '0;
            valid_s1 <= 1'b0;
        end else begin
            data_s1  <= rx_data ^ {n_width{invert}};
            valid_s1 <= rx_valid;
        end
    end

    // History of the last n_prbs received bits, advancing only on valid words.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            history <= '0;
        end else if (valid_s1) begin
            history <= hist_next;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state: mode 0 wins over everything else.
    always_comb begin
        next_state = state;
        if (!mode_active) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = SEED;
                SEED:    if (seed_done && !seed_zero) next_state = TRACK;
                TRACK:   if (loss_hit) next_state = SEED;
                default: next_state = IDLE;
            endcase
        end
    end

    // FSM outputs: lock flag plus per-cycle seed/count/relock strobes.
    always_comb begin
        locked     = (state == TRACK);
        load_seed  = 1'b0;
        count_now  = 1'b0;
        relock_inc = 1'b0;
        if (mode_active) begin
            load_seed  = (state == SEED) && seed_done && !seed_zero;
            count_now  = track_word && (checker_mode == mode_run);
            relock_inc = loss_hit && ((checker_mode == mode_align) ||
                                      (checker_mode == mode_run));
        end
    end

    // Seed word counter; an all-zero history restarts the count.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            seed_cnt <= '0;
        end else if ((state != SEED) || !mode_active) begin
            seed_cnt <= '0;
        end else if (valid_s1) begin
            seed_cnt <= seed_done ? '0 : seed_cnt + seed_w'(1);
        end
    end

    // Free-running LFSR: loaded from history at seed time, then advanced on its own predictions.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            lfsr <= '0;
        end else if (load_seed) begin
            lfsr <= hist_next;
        end else if (track_word) begin
            lfsr <= shift_in(lfsr, pred_word);
        end
    end

    // Consecutive bad-word counter for lock-loss detection.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            bad_cnt <= '0;
        end else if ((state != TRACK) || !mode_active || loss_hit) begin
            bad_cnt <= '0;
        end else if (track_word) begin
            if (!word_bad) begin
                bad_cnt <= '0;
            end else if (bad_cnt != '1) begin
                bad_cnt <= bad_cnt + n_thresh'(1);
            end
        end
    end

    // Stage 2: register the per-bit mismatch and the counting qualifier.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            err_signals <= '0;
            count_en    <= 1'b0;
        end else if (!mode_active) begin
            err_signals <= '0;
            count_en    <= 1'b0;
        end else begin
            count_en <= count_now;
            if (track_word) begin
                err_signals <= err_now;
            end
        end
    end

    // Stage 3: saturating bit and error accumulators.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            total_bits <= '0;
            err_bits   <= '0;
        end else if (!mode_active) begin
            total_bits <= '0;
            err_bits   <= '0;
        end else if (count_en) begin
            total_bits <= total_sum[n_cnt] ? '1 : total_sum[n_cnt-1:0];
            err_bits   <= err_sum[n_cnt]   ? '1 : err_sum[n_cnt-1:0];
        end
    end

    // Saturating count of automatic re-seeds; not bumped while frozen.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            relock_count <= '0;
        end else if (!mode_active) begin
            relock_count <= '0;
        end else if (relock_inc && (relock_count != '1)) begin
            relock_count <= relock_count + n_relock'(1);
        end
    end

endmodule

// File: tb/tb_prbs_checker_mlane.sv
// tb_prbs_checker_mlane: drives a PRBS21 stream into two checker instances
// (64-bit and 8-bit counters), checks err_signals per word through a
// scoreboard queue and counters/lock state at the end of each phase.

module tb_prbs_checker_mlane;

    logic        clk = 1'b0;
    logic        rstb;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic [31:0] prbs_eqn;
    logic        invert;
    logic [1:0]  checker_mode;
    logic [4:0]  lock_thresh;
    logic [4:0]  lock_loss_cycles;

    logic [63:0] err_bits;
    logic [63:0] total_bits;
    logic [15:0] relock_count;
    logic        locked;
    logic [15:0] err_signals;

    logic [7:0]  err_bits_s;
    logic [7:0]  total_bits_s;
    logic [15:0] relock_count_s;
    logic        locked_s;
    logic [15:0] err_signals_s;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;

    logic [31:0] gen_state = 32'h0000_0001;
    logic        src_inv = 1'b0;
    logic        src_zero = 1'b0;

    typedef struct {
        int unsigned due;
        logic [15:0] exp;
    } sb_t;

    sb_t sb_q[$];

    typedef struct {
        logic [1:0]  mode;
        logic        inv;
        int          words;
        int          skip;
        logic        toggle;
        int          flip_period;
        int          flip_phase;
        logic [15:0] flip;
        longint      exp_err;
        longint      exp_total;
        int          exp_relock;
        logic        exp_locked;
    } row_t;

    row_t rows[0:5];

    prbs_checker_mlane dut (
        .clk              (clk),
        .rstb             (rstb),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .prbs_eqn         (prbs_eqn),
        .invert           (invert),
        .checker_mode     (checker_mode),
        .lock_thresh      (lock_thresh),
        .lock_loss_cycles (lock_loss_cycles),
        .err_bits         (err_bits),
        .total_bits       (total_bits),
        .relock_count     (relock_count),
        .locked           (locked),
        .err_signals      (err_signals)
    );

    prbs_checker_mlane #(.n_cnt(8)) dut_sat (
        .clk              (clk),
        .rstb             (rstb),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .prbs_eqn         (prbs_eqn),
        .invert           (invert),
        .checker_mode     (checker_mode),
        .lock_thresh      (lock_thresh),
        .lock_loss_cycles (lock_loss_cycles),
        .err_bits         (err_bits_s),
        .total_bits       (total_bits_s),
        .relock_count     (relock_count_s),
        .locked           (locked_s),
        .err_signals      (err_signals_s)
    );

    always #5 clk = ~clk;

    // Cycle index: after the k-th rising edge, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference PRBS21 source: b[n] = b[n-2] ^ b[n-21], bit 0 of the word first.
    task automatic next_word(output logic [15:0] w);
        logic nb;
        for (int i = 0; i < 16; i++) begin
            nb        = gen_state[1] ^ gen_state[20];
            w[i]      = nb;
            gen_state = {gen_state[30:0], nb};
        end
    endtask

    // Drive one cycle; valid words may carry a flip mask and queue an expected err_signals.
    task automatic apply_stimulus(input logic valid, input logic [1:0] mode,
                                  input logic [15:0] flip, input logic push,
                                  input logic [15:0] exp);
        logic [15:0] w;
        sb_t         e;
        @(negedge clk);
        checker_mode = mode;
        rx_valid     = valid;
        if (valid) begin
            if (src_zero) begin
                rx_data = 16'h0000;
            end else begin
                next_word(w);
                rx_data = (w ^ flip) ^ {16{src_inv}};
            end
            if (push) begin
                e.due = cyc + 2;
                e.exp = exp;
                sb_q.push_back(e);
            end
        end else begin
            rx_data = 16'($urandom);
        end
    endtask

    task automatic idle(input int n, input logic [1:0] mode);
        repeat (n) apply_stimulus(1'b0, mode, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic check_counters(input string tag, input longint exp_err,
                                  input longint exp_total, input int exp_relock,
                                  input logic exp_locked);
        check_output({tag, " locked"}, 64'(locked), 64'(exp_locked));
        check_output({tag, " err_bits"}, err_bits, 64'(exp_err));
        check_output({tag, " total_bits"}, total_bits, 64'(exp_total));
        check_output({tag, " relock_count"}, 64'(relock_count), 64'(exp_relock));
        check_output({tag, " sat total_bits"}, 64'(total_bits_s),
                     64'((exp_total > 255) ? 255 : exp_total));
        check_output({tag, " sat err_bits"}, 64'(err_bits_s),
                     64'((exp_err > 255) ? 255 : exp_err));
    endtask

    task automatic run_row(input int idx);
        row_t        r;
        logic [15:0] f;
        r       = rows[idx];
        invert  = r.inv;
        src_inv = r.inv;
        for (int i = 0; i < r.words; i++) begin
            f = ((r.flip_period != 0) && ((i % r.flip_period) == r.flip_phase)) ? r.flip : 16'h0;
            apply_stimulus(1'b1, r.mode, f, (i >= r.skip), f);
            if (r.toggle) apply_stimulus(1'b0, r.mode, 16'h0, 1'b0, 16'h0);
        end
        idle(3, r.mode);
        check_counters($sformatf("row%0d", idx), r.exp_err, r.exp_total, r.exp_relock, r.exp_locked);
    endtask

    function automatic row_t mk(input logic [1:0] mode, input logic inv, input int words,
                                input int skip, input logic toggle, input int fp,
                                input int fph, input logic [15:0] flip, input longint e_err,
                                input longint e_tot, input int e_rel, input logic e_lock);
        row_t r;
        r.mode = mode; r.inv = inv; r.words = words; r.skip = skip; r.toggle = toggle;
        r.flip_period = fp; r.flip_phase = fph; r.flip = flip;
        r.exp_err = e_err; r.exp_total = e_tot; r.exp_relock = e_rel; r.exp_locked = e_lock;
        return r;
    endfunction

    // Scoreboard: compare queued err_signals expectations when they come due.
    always @(negedge clk) begin
        sb_t e;
        while (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            check_output($sformatf("err_signals@%0d", e.due), 64'(err_signals), 64'(e.exp));
            check_output($sformatf("sat err_signals@%0d", e.due), 64'(err_signals_s), 64'(e.exp));
        end
    end

    // Main sequence: reset, table rows, lock-loss, mode 0, all-zero, saturation, async reset.
    initial begin
        rows[0] = mk(2'd1, 1'b0,   10, 2, 1'b0,    0,   0, 16'h0000,  0,     0, 0, 1'b1);
        rows[1] = mk(2'd2, 1'b0, 1000, 0, 1'b0,    0,   0, 16'h0000,  0, 16000, 0, 1'b1);
        rows[2] = mk(2'd2, 1'b0, 1000, 0, 1'b0, 1000, 500, 16'h0020,  1, 32000, 0, 1'b1);
        rows[3] = mk(2'd2, 1'b1,  100, 0, 1'b0,    0,   0, 16'h0000,  1, 33600, 0, 1'b1);
        rows[4] = mk(2'd2, 1'b1, 1000, 0, 1'b1,    0,   0, 16'h0000, 49, 49968, 1, 1'b1);
        rows[5] = mk(2'd3, 1'b1,   50, 0, 1'b0,   10,   3, 16'h8001, 49, 49968, 1, 1'b1);

        rstb             = 1'b0;
        rx_data          = 16'h0;
        rx_valid         = 1'b0;
        prbs_eqn         = 32'h0010_0002;
        invert           = 1'b0;
        checker_mode     = 2'd0;
        lock_thresh      = 5'd4;
        lock_loss_cycles = 5'd0;

        repeat (3) @(negedge clk);
        check_counters("reset", 0, 0, 0, 1'b0);
        check_output("reset err_signals", 64'(err_signals), 64'h0);
        rstb = 1'b1;

        for (int i = 0; i < 4; i++) run_row(i);

        // Inverted source without inversion: three bad words force a re-seed.
        lock_loss_cycles = 5'd3;
        invert  = 1'b0;
        src_inv = 1'b1;
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 2'd2, 16'h0, 1'b1, 16'hFFFF);
        idle(3, 2'd2);
        check_counters("lockloss", 49, 33648, 1, 1'b0);
        invert = 1'b1;
        for (int i = 0; i < 22; i++) apply_stimulus(1'b1, 2'd2, 16'h0, (i >= 2), 16'h0);
        idle(3, 2'd2);
        check_counters("relocked", 49, 33968, 1, 1'b1);

        for (int i = 4; i < 6; i++) run_row(i);

        // One cycle of mode 0 clears everything synchronously.
        apply_stimulus(1'b0, 2'd0, 16'h0, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        check_counters("mode0", 0, 0, 0, 1'b0);
        check_output("mode0 err_signals", 64'(err_signals), 64'h0);

        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 2'd1, 16'h0, (i >= 2), 16'h0);
        idle(3, 2'd1);
        check_counters("reseed", 0, 0, 0, 1'b1);

        // All-zero data is a degenerate seed: the checker never locks.
        idle(1, 2'd0);
        invert   = 1'b0;
        src_zero = 1'b1;
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 2'd1, 16'h0, 1'b0, 16'h0);
        idle(3, 2'd1);
        check_counters("allzero", 0, 0, 0, 1'b0);

        // 20 clean words in run mode: the 8-bit instance saturates at 255.
        idle(1, 2'd0);
        src_zero = 1'b0;
        src_inv  = 1'b0;
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 2'd1, 16'h0, (i >= 2), 16'h0);
        idle(3, 2'd1);
        for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 2'd2, 16'h0, 1'b1, 16'h0);
        idle(3, 2'd2);
        check_counters("saturate", 0, 320, 0, 1'b1);
        check_output("saturate sat locked", 64'(locked_s), 64'h1);

        // Asynchronous reset mid-stream with words still in the pipeline.
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 2'd2, 16'h0, 1'b0, 16'h0);
        @(posedge clk);
        #2;
        rstb = 1'b0;
        #1;
        check_counters("asyncrst", 0, 0, 0, 1'b0);
        check_output("asyncrst err_signals", 64'(err_signals), 64'h0);
        repeat (2) @(negedge clk);
        check_output("asyncrst held total_bits", total_bits, 64'h0);

        check_output("scoreboard empty", 64'(sb_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
